// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe
//   EX->MEM pipeline stage with a valid/ready handshake and a two-entry skid
//   buffer. in_ready depends only on the skid valid bit, so it is a registered
//   signal. MEM back-pressure therefore never forms a combinational path back
//   into EX. A synchronous flush kills every held entry and the incoming one.
//   The side-effecting controls (rd_en, load/store flags) read as zero
//   whenever no entry is presented.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               synchronous kill of held and incoming entries
//   in_valid / in_ready EX-side handshake (in_ready is registered)
//   rd_in .. store_data_in      entry fields from EX
//   out_valid / out_ready       MEM-side handshake
//   rd_out .. store_data_out    presented entry (controls gated by out_valid)
//   load_pending        a valid load is presented (for the hazard unit)
module ex_mem_pipe #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int LOAD_W  = 5,
  parameter int STORE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    rd_in,
  input  logic               rd_en_in,
  input  logic [REG_AW-1:0]  rd_addr_in,
  input  logic [LOAD_W-1:0]  load_flag_in,
  input  logic [STORE_W-1:0] store_flag_in,
  input  logic [XLEN-1:0]    store_data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    rd_out,
  output logic               rd_en_out,
  output logic [REG_AW-1:0]  rd_addr_out,
  output logic [LOAD_W-1:0]  load_flag_out,
  output logic [STORE_W-1:0] store_flag_out,
  output logic [XLEN-1:0]    store_data_out,
  output logic               load_pending
);

  typedef struct packed {
    logic [XLEN-1:0]    rd;
    logic               rd_en;
    logic [REG_AW-1:0]  rd_addr;
    logic [LOAD_W-1:0]  load_flag;
    logic [STORE_W-1:0] store_flag;
    logic [XLEN-1:0]    store_data;
  } entry_t;

  entry_t in_e;
  entry_t m_q, m_d;   // main entry, drives the outputs
  entry_t s_q, s_d;   // skid entry
  logic   m_v, m_v_d;
  logic   s_v, s_v_d;
  logic   acc, pop;

  assign in_e = {rd_in, rd_en_in, rd_addr_in, load_flag_in, store_flag_in, store_data_in};

  // S can only be occupied when M is, so a free S slot is the whole story.
  assign in_ready = ~s_v;
  assign acc      = in_valid & in_ready & ~flush;
  assign pop      = m_v & out_ready;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    m_v_d = m_v;
    s_v_d = s_v;
    m_d   = m_q;
    s_d   = s_q;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      m_v_d = 1'b0;
      s_v_d = 1'b0;
    end else if (pop) begin
      if (s_v) begin
        m_d = s_q;
        if (acc) s_d   = in_e;
        else     s_v_d = 1'b0;
      end else begin
        if (acc) m_d   = in_e;
        else     m_v_d = 1'b0;
      end
    end else if (!m_v) begin
      if (acc) begin
        m_d   = in_e;
        m_v_d = 1'b1;
      end
    end else if (acc) begin
      // M is stalled: the one extra entry in flight lands in S.
      s_d   = in_e;
      s_v_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_q <= '0;
    end else begin
      m_v <= m_v_d;
      s_v <= s_v_d;
      m_q <= m_d;
    end
  end

  // NOTE: the skid data is never observed unless s_v is set, so it carries no
  // reset; only valid bits and the output-visible main entry are reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

  assign out_valid      = m_v;
  assign rd_out         = m_q.rd;
  assign rd_addr_out    = m_q.rd_addr;
  assign store_data_out = m_q.store_data;
  assign rd_en_out      = m_v & m_q.rd_en;
  assign load_flag_out  = m_v ? m_q.load_flag  : '0;
  assign store_flag_out = m_v ? m_q.store_flag : '0;
  assign load_pending   = m_v & (|m_q.load_flag);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe
//   Self-checking bench for ex_mem_pipe: reset values, a table of directed
//   back-pressure / flush vectors, streaming, load gating, asynchronous reset
//   mid-stream, and a randomized run against a bounded-FIFO reference model.
module tb_ex_mem_pipe;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int LOAD_W  = 5;
  localparam int STORE_W = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    rd_in;
  logic               rd_en_in;
  logic [REG_AW-1:0]  rd_addr_in;
  logic [LOAD_W-1:0]  load_flag_in;
  logic [STORE_W-1:0] store_flag_in;
  logic [XLEN-1:0]    store_data_in;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    rd_out;
  logic               rd_en_out;
  logic [REG_AW-1:0]  rd_addr_out;
  logic [LOAD_W-1:0]  load_flag_out;
  logic [STORE_W-1:0] store_flag_out;
  logic [XLEN-1:0]    store_data_out;
  logic               load_pending;

  ex_mem_pipe #(
    .XLEN(XLEN), .REG_AW(REG_AW), .LOAD_W(LOAD_W), .STORE_W(STORE_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_in(rd_in), .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in),
    .load_flag_in(load_flag_in), .store_flag_in(store_flag_in),
    .store_data_in(store_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_out(rd_out), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
    .load_flag_out(load_flag_out), .store_flag_out(store_flag_out),
    .store_data_out(store_data_out), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vector: inputs for one cycle, expected state after the edge.
  typedef struct {
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic        exp_valid;
    logic        exp_ready;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  // Reference entry for the randomized run.
  typedef struct {
    logic [XLEN-1:0]    rd;
    logic               rd_en;
    logic [REG_AW-1:0]  rd_addr;
    logic [LOAD_W-1:0]  load_flag;
    logic [STORE_W-1:0] store_flag;
    logic [XLEN-1:0]    store_data;
  } ent_t;

  ent_t q[$];

  task automatic idle_inputs();
    flush         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    rd_in         = '0;
    rd_en_in      = 1'b0;
    rd_addr_in    = '0;
    load_flag_in  = '0;
    store_flag_in = '0;
    store_data_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // Table: back-pressure A,B,C then release; then flush with A in M, B in S.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 1'b1, 32'hA};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 1'b1, 32'hA};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 1'b1, 32'hA};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hC};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'hA, 1'b1, 1'b1, 1'b1, 32'hA};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 1'b1, 32'hA};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};

    // Reset values.
    #2;
    check("reset out_valid",  out_valid, 0);
    check("reset in_ready",   in_ready, 1);
    check("reset rd_out",     rd_out, 0);
    check("reset rd_en_out",  rd_en_out, 0);
    check("reset rd_addr",    rd_addr_out, 0);
    check("reset load_flag",  load_flag_out, 0);
    check("reset store_flag", store_flag_out, 0);
    check("reset store_data", store_data_out, 0);
    check("reset load_pend",  load_pending, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      flush         = vecs[i].flush;
      in_valid      = vecs[i].in_valid;
      out_ready     = vecs[i].out_ready;
      rd_in         = vecs[i].rd;
      rd_en_in      = 1'b1;
      rd_addr_in    = 5'd3;
      load_flag_in  = 5'd3;
      store_flag_in = 3'd2;
      store_data_in = 32'h55;
      step();
      check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_ready);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rd_out", i), rd_out, vecs[i].exp_rd);
      check($sformatf("vec%0d rd_en_out", i), rd_en_out, vecs[i].exp_valid);
      check($sformatf("vec%0d load_flag", i), load_flag_out, vecs[i].exp_valid ? 3 : 0);
      check($sformatf("vec%0d store_flag", i), store_flag_out, vecs[i].exp_valid ? 2 : 0);
    end
    idle_inputs();

    // Streaming: 8 back-to-back entries with MEM always ready.
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rd_in     = 32'h10 + i;
      rd_en_in  = 1'b1;
      step();
      check($sformatf("stream%0d out_valid", i), out_valid, 1);
      check($sformatf("stream%0d rd_out", i), rd_out, 32'h10 + i);
      check($sformatf("stream%0d in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream drain out_valid", out_valid, 0);
    idle_inputs();

    // Load gating / hazard.
    in_valid     = 1'b1;
    rd_en_in     = 1'b1;
    rd_addr_in   = 5'd7;
    load_flag_in = 5'h1;
    rd_in        = 32'h1234;
    step();
    check("load load_pending", load_pending, 1);
    check("load load_flag",    load_flag_out, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("popped load_pending", load_pending, 0);
    check("popped load_flag",    load_flag_out, 0);
    check("popped rd_en_out",    rd_en_out, 0);
    check("popped rd_addr_out",  rd_addr_out, 7);
    idle_inputs();

    // Asynchronous reset with two entries held.
    in_valid = 1'b1;
    rd_en_in = 1'b1;
    rd_in    = 32'hAA;
    step();
    rd_in = 32'hBB;
    step();
    in_valid = 1'b0;
    check("pre-reset in_ready",  in_ready, 0);
    check("pre-reset out_valid", out_valid, 1);
    #1 rst = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset rd_en_out", rd_en_out, 0);
    check("async reset in_ready",  in_ready, 1);
    check("async reset rd_out",    rd_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_inputs();

    // Randomized run against a capacity-2 FIFO model.
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      bit   pop_m, acc_m;
      ent_t e;
      check("rnd out_valid", out_valid, q.size() != 0);
      check("rnd in_ready",  in_ready, q.size() < 2);
      if (q.size() != 0) begin
        check("rnd rd_out",     rd_out, q[0].rd);
        check("rnd rd_en_out",  rd_en_out, q[0].rd_en);
        check("rnd rd_addr",    rd_addr_out, q[0].rd_addr);
        check("rnd load_flag",  load_flag_out, q[0].load_flag);
        check("rnd store_flag", store_flag_out, q[0].store_flag);
        check("rnd store_data", store_data_out, q[0].store_data);
        check("rnd load_pend",  load_pending, q[0].load_flag != 0);
      end else begin
        check("rnd bubble rd_en",   rd_en_out, 0);
        check("rnd bubble load",    load_flag_out, 0);
        check("rnd bubble store",   store_flag_out, 0);
        check("rnd bubble pending", load_pending, 0);
      end

      e.rd         = $urandom;
      e.rd_en      = 1'($urandom);
      e.rd_addr    = 5'($urandom);
      e.load_flag  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      e.store_flag = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      e.store_data = $urandom;

      flush         = ($urandom_range(0, 15) == 0);
      in_valid      = ($urandom_range(0, 9) < 7);
      out_ready     = ($urandom_range(0, 9) < 6);
      rd_in         = e.rd;
      rd_en_in      = e.rd_en;
      rd_addr_in    = e.rd_addr;
      load_flag_in  = e.load_flag;
      store_flag_in = e.store_flag;
      store_data_in = e.store_data;

      pop_m = (q.size() != 0) && out_ready;
      acc_m = in_valid && (q.size() < 2) && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (pop_m) void'(q.pop_front());
        if (acc_m) q.push_back(e);
      end
      step();
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage for the RISC-V core, replacing the fixed-width, always-advancing EX/MEM register. It carries the ALU result, the writeback controls and the load/store controls from EX to MEM. It adds a valid/ready handshake, a two-entry skid buffer so that `in_ready` is a registered signal, a synchronous flush, and bubble gating of all side-effecting controls. MEM back-pressure (e.g. a data-memory wait) therefore stalls EX without a combinational ready path.

## Interface
Parameters:
- `XLEN`, 32: data width of `rd_*` and `store_data_*`
- `REG_AW`, 5: register-address width
- `LOAD_W`, 5: load-flag width; encoding 0 = no load
- `STORE_W`, 3: store-flag width; encoding 0 = no store

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous kill of all held and incoming entries
- `in_valid`  in  1  EX presents an entry
- `in_ready`  out  1  stage can accept; registered
- `rd_in`  in  XLEN  result / address
- `rd_en_in`  in  1  writeback enable
- `rd_addr_in`  in  REG_AW  destination register
- `load_flag_in`  in  LOAD_W  load type
- `store_flag_in`  in  STORE_W  store type
- `store_data_in`  in  XLEN  store data
- `out_valid`  out  1  entry presented to MEM
- `out_ready`  in  1  MEM consumes the entry
- `rd_out`, `rd_en_out`, `rd_addr_out`, `load_flag_out`, `store_flag_out`, `store_data_out`  out  as inputs  presented entry
- `load_pending`  out  1  `out_valid && load_flag_out != 0`; used by the hazard unit

## Operation
- Storage: main entry M (drives the outputs) and skid entry S, each with a valid bit (`m_v`, `s_v`).
- Accept: `acc = in_valid && in_ready && !flush`.
- Pop: `pop = m_v && out_ready`.
- `in_ready = !s_v`, registered. No combinational path from `out_ready` to `in_ready`.
- Update order per cycle, with `flush` overriding everything:
  - `flush`: `m_v` ← 0 and `s_v` ← 0. The input is dropped. Data registers need not clear.
  - `pop && s_v`: M ← S. If `acc`, S ← input; else `s_v` ← 0.
  - `pop && !s_v`: if `acc`, M ← input; else `m_v` ← 0.
  - `!pop && !m_v`: if `acc`, M ← input and `m_v` ← 1.
  - `!pop && m_v`: if `acc`, S ← input and `s_v` ← 1.
- The `acc` case with `m_v && !pop && s_v` cannot occur, because `in_ready` = 0 when `s_v` = 1.
- Bubble gating: `rd_en_out`, `load_flag_out` and `store_flag_out` are forced to 0 whenever `out_valid` = 0. `rd_out`, `rd_addr_out` and `store_data_out` show M's data unmodified.
- `out_valid = m_v`. Entries leave in strict FIFO order; no reordering, no duplication.

## Timing
- Reset (`rst` low, asynchronous), all outputs:
  - `out_valid` = 0, `in_ready` = 1
  - `rd_out` = 0, `rd_en_out` = 0, `rd_addr_out` = 0
  - `load_flag_out` = 0, `store_flag_out` = 0, `store_data_out` = 0
  - `load_pending` = 0
  - Both valid bits = 0.
- Reset deassertion is used as-is (no internal synchroniser); first accept is possible on the first edge after `rst` rises.
- Latency: an entry accepted at edge N is on the outputs with `out_valid` = 1 after edge N when the stage was empty or popping with `s_v` = 0.
- Throughput: 1 entry/cycle with `out_ready` held high; S stays empty.
- `out_ready` low with M valid: one further entry lands in S; `in_ready` drops after that edge. With both entries held, `in_ready` = 0.
- `in_ready` returns to 1 the edge after the pop that empties S.
- Holding: while `out_valid` = 1 and `out_ready` = 0, all outputs are stable.
- `flush` together with `pop`: the popped entry counts as consumed by MEM this cycle. After the edge both entries are invalid and `in_ready` = 1.
- `flush` together with `in_valid`: the input is not accepted. EX must treat it as killed.
- Reset mid-operation: held entries are lost immediately; outputs take reset values asynchronously.

## Test plan
- Reset: drive `rst` low mid-stream with two entries held → `out_valid` = 0, `rd_en_out` = 0, `in_ready` = 1 with no clock edge.
- Streaming: 8 back-to-back entries (`rd_in` = 0x10..0x17), `out_ready` = 1 → each appears 1 cycle after acceptance, in order; `in_ready` stays 1.
- Back-pressure:
  - Stimulus: `out_ready` = 0 while sending A = 0xA, B = 0xB, C = 0xC.
  - Response: A held on outputs; B in S; `in_ready` = 0 from the edge after B; C not accepted.
  - Release: set `out_ready` = 1 → A, B, C delivered in order; `in_ready` back to 1 the cycle after S empties.
- Flush:
  - Stimulus: with A in M and B in S, assert `flush` together with `in_valid` (C = 0xC).
  - Response: next cycle `out_valid` = 0 and `in_ready` = 1; C never appears.
  - Bubble: `rd_en_out` = `store_flag_out` = `load_flag_out` = 0.
- Gating/hazard: accept a load (`load_flag_in` = 5'h1, `rd_addr_in` = 7), then let it pop with no refill.
  - While presented: `load_pending` = 1.
  - After the pop: `load_pending` = 0, `load_flag_out` = 0, `rd_en_out` = 0, `rd_addr_out` still 7.
- Random: random `in_valid`/`out_ready`/`flush` over 10k cycles against a 2-deep FIFO scoreboard → no loss except flushed entries, no duplication, outputs stable while stalled.
